// File: rtl/sha256_block_loader_pkg.sv
// Shared widths, bank geometry and read-FSM encodings for the SHA-256 block loader.
// SHA256_LOADER_DOUBLE_BUF_EN selects two ping-pong banks instead of one.
package sha256_block_loader_pkg;

  localparam int WORD        = 32;
  localparam int LONG        = 64;
  localparam int BLOCK_WORDS = 16;

`ifdef SHA256_LOADER_DOUBLE_BUF_EN
  localparam int NBANKS = 2;
`else
  localparam int NBANKS = 1;
`endif

  typedef enum logic [2:0] {
    R_IDLE  = 3'b001,
    R_ISSUE = 3'b010,
    R_WAIT  = 3'b100
  } rstate_e;

  // Message length in bits from whole words before the last one plus its byte count.
  function automatic logic [LONG-1:0] size_bits(
    input logic [LONG-1:0] words,
    input logic [1:0]      lb
  );
    logic [LONG-1:0] tail;
    tail = (lb == 2'd0) ? 64'd32 : {59'd0, lb, 3'd0};
    return (words << 5) + tail;
  endfunction

endpackage

// File: rtl/sha256_block_loader_bank_ram.sv
// 16x32 block bank: one write port, registered synchronous read.
// Only the read register is reset; bank contents are tracked by the loader's full flags.
module sha256_bank_ram
  import sha256_block_loader_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            we_i,
  input  logic [3:0]      waddr_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic [3:0]      raddr_i,
  output logic [WORD-1:0] rdata_o
);

  logic [WORD-1:0] mem_q [BLOCK_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_o <= '0;
    else       rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sha256_block_loader.sv
// Buffers a word stream into 16-word blocks and sequences sha256_update over them.
// SHA256_LOADER_DOUBLE_BUF_EN enables ping-pong banks so loading overlaps hashing.
module sha256_block_loader
  import sha256_block_loader_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [WORD-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_last,
  input  logic [1:0]      s_last_bytes,
  input  logic [3:0]      rd_offset,
  output logic [WORD-1:0] rd_word,
  output logic            update,
  input  logic            hash_done,
  output logic [LONG-1:0] msg_size,
  output logic            msg_done
);

  rstate_e         state_q;
  logic            update_q, done_q, ready_q, ready_d;
  logic            rbank_q, rsel_q;
  logic            wbank_q, wbank_d, fbank_q, fbank_d;
  logic [1:0]      full_q, full_d;
  logic [3:0]      wptr_q, wptr_d;
  logic            last_q, last_d, fill_q, fill_d, fin_q, fin_d;
  logic [LONG-1:0] cnt_q, cnt_d, size_q, size_d;
  logic            accept, we, rel, rel_fin;
  logic [WORD-1:0] wdata;
  logic [WORD-1:0] rdata [2];

  assign accept  = s_valid && ready_q;
  assign we      = accept || fill_q;
  assign wdata   = fill_q ? '0 : s_data;
  assign rel     = (state_q == R_WAIT) && hash_done;
  assign rel_fin = rel && fin_q && (fbank_q == rbank_q);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NBANKS) begin : g_ram
      sha256_bank_ram u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we && (wbank_q == 1'(b))),
        .waddr_i (wptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_offset),
        .rdata_o (rdata[b])
      );
    end else begin : g_none
      assign rdata[b] = '0;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    wbank_d = wbank_q;
    full_d  = full_q;
    last_d  = last_q;
    fill_d  = fill_q;
    fin_d   = fin_q;
    fbank_d = fbank_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    if (rel) full_d[rbank_q] = 1'b0;
    if (we) wptr_d = wptr_q + 4'd1;
    if (accept) begin
      if (s_last) begin
        last_d = 1'b1;
        size_d = size_bits(cnt_q, s_last_bytes);
        fill_d = (wptr_q != 4'hf);
      end else begin
        cnt_d = cnt_q + 64'd1;
      end
    end
    // Last slot written (data or zero fill): the bank is complete.
    if (we && (wptr_q == 4'hf)) begin
      fill_d          = 1'b0;
      full_d[wbank_q] = 1'b1;
      if (NBANKS == 2) wbank_d = ~wbank_q;
      if (last_d) begin
        fin_d   = 1'b1;
        fbank_d = wbank_q;
      end
    end
    if (rel_fin) begin
      last_d = 1'b0;
      fin_d  = 1'b0;
      cnt_d  = '0;
      size_d = '1;
    end
    ready_d = !full_d[wbank_d] && !last_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      wbank_q <= 1'b0;
      full_q  <= '0;
      last_q  <= 1'b0;
      fill_q  <= 1'b0;
      fin_q   <= 1'b0;
      fbank_q <= 1'b0;
      cnt_q   <= '0;
      size_q  <= '1;
      ready_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      wbank_q <= wbank_d;
      full_q  <= full_d;
      last_q  <= last_d;
      fill_q  <= fill_d;
      fin_q   <= fin_d;
      fbank_q <= fbank_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= R_IDLE;
      update_q <= 1'b0;
      done_q   <= 1'b0;
      rbank_q  <= 1'b0;
      rsel_q   <= 1'b0;
    end else begin
      update_q <= 1'b0;
      done_q   <= rel_fin;
      rsel_q   <= rbank_q;
      unique case (state_q)
        R_IDLE: begin
          if (full_q[rbank_q]) begin
            state_q  <= R_ISSUE;
            update_q <= 1'b1;
          end
        end
        R_ISSUE: state_q <= R_WAIT;
        R_WAIT: begin
          if (hash_done) begin
            state_q <= R_IDLE;
            if (NBANKS == 2) rbank_q <= ~rbank_q;
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign s_ready  = ready_q;
  assign update   = update_q;
  assign msg_done = done_q;
  assign msg_size = size_q;
  assign rd_word  = rdata[rsel_q];

endmodule

// File: tb/tb_sha256_block_loader.sv
// Randomized bench: a producer streams messages while a stand-in hash engine reads each block.
// Expected blocks and sizes come from a word-queue model of the message.
module tb_sha256_block_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic [1:0]  s_last_bytes = '0;
  logic [3:0]  rd_offset = '0;
  logic [31:0] rd_word;
  logic        update;
  logic        hash_done = 1'b0;
  logic [63:0] msg_size;
  logic        msg_done;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [31:0] msg [$];
  int          n_words;
  logic [1:0]  lbytes;
  int          gap_max;
  int          hash_dly;
  bit          b2b;
  int          t_hd1, t_acc16, stalls;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  sha256_block_loader dut (
    .clk          (clk),
    .reset        (reset),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_last       (s_last),
    .s_last_bytes (s_last_bytes),
    .rd_offset    (rd_offset),
    .rd_word      (rd_word),
    .update       (update),
    .hash_done    (hash_done),
    .msg_size     (msg_size),
    .msg_done     (msg_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_word(input int b, input int k);
    int idx;
    idx = b * 16 + k;
    return (idx < msg.size()) ? msg[idx] : 32'd0;
  endfunction

  function automatic logic [63:0] exp_size();
    logic [63:0] tail;
    tail = (lbytes == 2'd0) ? 64'd32 : 64'(lbytes) * 64'd8;
    return 64'(n_words - 1) * 64'd32 + tail;
  endfunction

  task automatic produce();
    int guard;
    stalls  = 0;
    t_acc16 = -1;
    for (int i = 0; i < n_words; i++) begin
      @(negedge clk);
      if (gap_max > 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
      if (i == n_words - 1) begin
        compared++;
        if (msg_size !== ONES) begin
          mismatched++;
          $display("FAIL size_before_last: got %h want %h", msg_size, ONES);
        end
      end
      s_data       = msg[i];
      s_valid      = 1'b1;
      s_last       = (i == n_words - 1);
      s_last_bytes = lbytes;
      guard = 0;
      while (s_ready !== 1'b1 && guard < 3000) begin
        @(negedge clk);
        guard++;
        stalls++;
      end
      if (guard >= 3000) begin
        compared++;
        mismatched++;
        $display("FAIL ready_timeout: word %0d got s_ready=%b want 1", i, s_ready);
      end
      if (i == 16) t_acc16 = cyc;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    compared++;
    if (msg_size !== exp_size()) begin
      mismatched++;
      $display("FAIL size_after_last: got %0d want %0d", msg_size, exp_size());
    end
  endtask

  task automatic consume();
    int nblk, guard;
    bit fin;
    nblk  = (n_words + 15) / 16;
    t_hd1 = -1;
    for (int b = 0; b < nblk; b++) begin
      fin   = (b == nblk - 1);
      guard = 0;
      while (update !== 1'b1 && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      compared++;
      if (guard >= 3000) begin
        mismatched++;
        $display("FAIL update_timeout: block %0d got update=%b want 1", b, update);
        return;
      end
`ifndef SHA256_LOADER_DOUBLE_BUF_EN
      if (b == 0 && n_words > 16) begin
        compared++;
        if (s_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL ready_while_full: got %b want 0", s_ready);
        end
      end
`endif
      rd_offset = 4'd0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (k == 0) begin
          compared++;
          if (update !== 1'b0) begin
            mismatched++;
            $display("FAIL update_pulse: got %b want 0", update);
          end
        end
        compared++;
        if (rd_word !== exp_word(b, k)) begin
          mismatched++;
          $display("FAIL rd_word b%0d k%0d: got %h want %h", b, k, rd_word, exp_word(b, k));
        end
        rd_offset = 4'(k + 1);
      end
      repeat (hash_dly) @(negedge clk);
      hash_done = 1'b1;
      if (b == 0) t_hd1 = cyc;
      @(negedge clk);
      hash_done = 1'b0;
      compared++;
      if (msg_done !== fin) begin
        mismatched++;
        $display("FAIL msg_done b%0d: got %b want %b", b, msg_done, fin);
      end
      if (fin) begin
        compared++;
        if (msg_size !== ONES) begin
          mismatched++;
          $display("FAIL size_restore: got %h want %h", msg_size, ONES);
        end
      end
      @(negedge clk);
      compared++;
      if (msg_done !== 1'b0) begin
        mismatched++;
        $display("FAIL msg_done_pulse: got %b want 0", msg_done);
      end
      if (b2b && !fin) begin
        compared++;
        if (update !== 1'b1) begin
          mismatched++;
          $display("FAIL back_to_back_update: got %b want 1", update);
        end
      end
    end
  endtask

  task automatic run_msg();
    bit extra;
    fork
      produce();
      consume();
    join
    extra = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (update === 1'b1) extra = 1'b1;
    end
    compared++;
    if (extra !== 1'b0) begin
      mismatched++;
      $display("FAIL extra_update: got %b want 0", extra);
    end
  endtask

  task automatic fill_msg(input int n, input bit counting);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(counting ? 32'(i) : $urandom);
    n_words = n;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({s_ready, update, msg_done} !== 3'b000 || rd_word !== 32'd0 || msg_size !== ONES) begin
      mismatched++;
      $display("FAIL reset_state: got rdy=%b upd=%b done=%b rd=%h size=%h want 0 0 0 0 ones",
               s_ready, update, msg_done, rd_word, msg_size);
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_after_reset: got %b want 1", s_ready);
    end
  endtask

  task automatic test_full_block();
    fill_msg(16, 1'b1);
    lbytes = 2'd0; gap_max = 0; hash_dly = 5; b2b = 1'b0;
    run_msg();
  endtask

  task automatic test_partial();
    fill_msg(3, 1'b0);
    lbytes = 2'd1; gap_max = 0; hash_dly = 3; b2b = 1'b0;
    run_msg();
  endtask

  task automatic test_back_to_back();
    fill_msg(32, 1'b0);
    lbytes = 2'd0; gap_max = 0; hash_dly = 40;
`ifdef SHA256_LOADER_DOUBLE_BUF_EN
    b2b = 1'b1;
`else
    b2b = 1'b0;
`endif
    run_msg();
`ifdef SHA256_LOADER_DOUBLE_BUF_EN
    compared++;
    if (stalls !== 0) begin
      mismatched++;
      $display("FAIL no_stall: got %0d stalls want 0", stalls);
    end
`else
    compared++;
    if (!(t_acc16 > t_hd1)) begin
      mismatched++;
      $display("FAIL word16_after_done: got accept %0d want after %0d", t_acc16, t_hd1);
    end
`endif
  endtask

  task automatic test_random();
    for (int m = 0; m < 6; m++) begin
      fill_msg($urandom_range(40, 1), 1'b0);
      lbytes   = 2'($urandom_range(3, 0));
      gap_max  = 3;
      hash_dly = $urandom_range(20, 2);
      b2b      = 1'b0;
      run_msg();
    end
  endtask

  task automatic test_reset_mid();
    bit bad_upd, bad_size;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_data = 32'(i); s_valid = 1'b1; s_last = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_after_mid_reset: got %b want 1", s_ready);
    end
    bad_upd = 1'b0; bad_size = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (update === 1'b1) bad_upd = 1'b1;
      if (msg_size !== ONES) bad_size = 1'b1;
    end
    compared++;
    if (bad_upd !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_update: got %b want 0", bad_upd);
    end
    compared++;
    if (bad_size !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_size: got %b want 0", bad_size);
    end
    fill_msg(5, 1'b0);
    lbytes = 2'd2; gap_max = 0; hash_dly = 4; b2b = 1'b0;
    run_msg();
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_partial();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
